// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_ctrl
// Description : SLC-3 bus controller: Req/Ready handshake to SRAM with
//               programmable wait states, plus an optional switch/hex I/O
//               register at IO_ADDR (enabled by defining MEMIO_HEX_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF,
    parameter int                NUM_HEX     = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Req,
    input  logic                 We,
    input  logic [ADDR_W-1:0]    Addr,
    input  logic [DATA_W-1:0]    Wdata,
    output logic [DATA_W-1:0]    Rdata,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Mem_OE,
    output logic                 Mem_WE,
    output logic [ADDR_W-1:0]    Mem_Addr,
    output logic [DATA_W-1:0]    Mem_Dout,
    input  logic [DATA_W-1:0]    Mem_Din,
    input  logic [DATA_W-1:0]    SW,
    output logic [4*NUM_HEX-1:0] Hex_out
);

    localparam int c_CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int c_HEX_W = 4 * NUM_HEX;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WAIT_STATES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

`ifdef MEMIO_HEX_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_IO     = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd3
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_dout;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_io_hit;

`ifdef MEMIO_HEX_EN
    logic [c_HEX_W-1:0]  r_hex_wdata;
    logic [c_HEX_W-1:0]  r_hex;

    assign w_io_hit = (Addr == IO_ADDR);
    assign Hex_out  = r_hex;
`else
    // No I/O decode: the display mirrors the SRAM address for debug.
    logic w_unused_io;

    assign w_unused_io = ^{SW, IO_ADDR};
    assign w_io_hit    = 1'b0;
    assign Hex_out     = r_mem_addr[c_HEX_W-1:0];
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Req) begin
`ifdef MEMIO_HEX_EN
                    w_state_nxt = w_io_hit ? S_IO : S_ACCESS;
`else
                    w_state_nxt = S_ACCESS;
`endif
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
`ifdef MEMIO_HEX_EN
            S_IO:     w_state_nxt = S_DONE;
`endif
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dout  <= '0;
            r_rdata     <= '0;
`ifdef MEMIO_HEX_EN
            r_hex_wdata <= '0;
            r_hex       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_we <= We;
                        // I/O accesses must leave the SRAM address/data bus untouched.
                        if (!w_io_hit) begin
                            r_cnt      <= c_CNT_LOAD;
                            r_mem_addr <= Addr;
                            r_mem_dout <= Wdata;
                        end
`ifdef MEMIO_HEX_EN
                        else begin
                            r_hex_wdata <= Wdata[c_HEX_W-1:0];
                        end
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (!r_we) begin
                        r_rdata <= Mem_Din;
                    end
                end
`ifdef MEMIO_HEX_EN
                S_IO: begin
                    if (r_we) begin
                        r_hex <= r_hex_wdata;
                    end else begin
                        r_rdata <= SW;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign Mem_OE   = (r_state == S_ACCESS) && !r_we;
    assign Mem_WE   = (r_state == S_ACCESS) &&  r_we;
    assign Ready    = (r_state == S_DONE);
    assign Busy     = (r_state != S_IDLE);
    assign Rdata    = r_rdata;
    assign Mem_Addr = r_mem_addr;
    assign Mem_Dout = r_mem_dout;

endmodule
`default_nettype wire
